acc_alu_seq: RTL and testbench
==============================

// Module: acc_alu_seq
// PURPOSE
//  Parametrised accumulator datapath, successor to the 8-bit one-hot datapath.
//  Encoded opcodes, valid/ready issue handshake, status flags, and multi-cycle
//  SHL/SHR (1 bit per cycle) and MUL (shift-add). Sits between control FSM and memory.
// PARAMETERS
//  WIDTH  8  accumulator/operand width (>=4)
//  IMM_W  4  immediate width, zero-extended to WIDTH
// PORTS
//  clka        in   1      single clock, all state on rising edge
//  restart     in   1      asynchronous active-high reset
//  acc_load    in   1      load acc_in into accumulator (IDLE only)
//  acc_in      in   WIDTH  accumulator load value
//  op_valid    in   1      opcode/operand presented
//  op_ready    out  1      = (state==IDLE) && !acc_load; transfer when valid&&ready
//  opcode      in   4      0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 NOT,7 SHL,8 SHR,9 MUL,10 LDA
//  use_imm     in   1      1: operand = zext(imm), 0: operand_in
//  imm         in   IMM_W  immediate
//  operand_in  in   WIDTH  memory operand
//  acc_out     out  WIDTH  accumulator (registered)
//  flags       out  4      {Z,N,C,V}, registered
//  busy        out  1      high in SHIFT/MUL states
//  done        out  1      one-cycle pulse, op complete; acc_out/flags valid
//  err         out  1      one-cycle pulse with done for opcodes 11-15
// BEHAVIOUR
//  Reset (async, any state): state IDLE, acc_out 0, flags 0, busy/done/err 0, counters 0.
//  States: IDLE, SHIFT, MUL. Opcode and selected operand captured on accept edge.
//  acc_load in IDLE: acc<=acc_in next edge, flags unchanged, no done; ignored when busy.
//  Single-cycle ops (NOP,ADD,SUB,AND,OR,XOR,NOT,LDA, illegal): result on accept edge,
//   done high the following cycle (latency 1); back-to-back accepts allowed.
//  ADD: acc+op mod 2^WIDTH, C=carry out, V=signed overflow.
//  SUB: acc-op, C=1 on borrow (acc<op unsigned), V=signed overflow.
//  AND/OR/XOR with acc; NOT: acc<=~op; LDA: acc<=op. These clear C,V.
//  NOP: acc and flags unchanged, done pulses. Illegal: as NOP plus err pulse.
//  Z=(result==0), N=result[WIDTH-1]; all flags update only on completion edge.
//  SHL/SHR: amount n=min(op,WIDTH). n=0: completes as single-cycle op, C=0.
//   else SHIFT state, one logical shift per cycle; done on edge after nth shift;
//   C=last bit shifted out, V=0. Latency n cycles; busy high cycles 1..n-1 after accept.
//  MUL: unsigned acc*op, exactly WIDTH iterations in MUL state; acc<=low WIDTH bits,
//   C=V=(high WIDTH bits !=0). Latency WIDTH cycles.
//  While busy: op_ready=0, op_valid ignored, acc_load ignored, acc_out holds old value
//   until completion edge (working regs internal).
//  done and op_ready may coincide: new op accepted in the done cycle.
//  restart mid SHIFT/MUL: aborts, no done, outputs to reset values.
// TESTING
//  ADD: acc=8'hF0, operand_in 8'h20 -> next cycle acc_out 8'h10, done=1, C=1,Z=0,V=0
//  SUBI: acc=5, imm 5 -> acc_out 0, Z=1,C=0; then SUBI 1 -> 8'hFF, N=1,C=1
//  SHL: acc=8'h81, imm 3 -> busy 2 cycles, done on 3rd, acc_out 8'h08, C=0
//  MUL: acc=13, operand 11 -> done after 8 cycles, acc_out 8'h8F, C=0;
//   acc=16*16 -> acc_out 0, Z=1,C=V=1
//  Backpressure: op_valid held during MUL -> op_ready 0, no accept until done cycle
//  restart pulsed mid-MUL -> acc_out 0, flags 0, busy 0 immediately, no done; opcode 12 -> err+done

Source files
------------

// File: rtl/acc_alu_seq.sv
// acc_alu_seq: parametrised accumulator datapath with encoded opcodes, a
// valid/ready issue handshake, {Z,N,C,V} status flags, bit-serial SHL/SHR
// (one bit per cycle) and a shift-add multiplier (WIDTH iterations).
// The architectural accumulator and flags only change on completion edges;
// multi-cycle operations run on private working registers.
module acc_alu_seq #(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4
) (
    input  logic              clka,
    input  logic              restart,
    input  logic              acc_load,
    input  logic [WIDTH-1:0]  acc_in,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        opcode,
    input  logic              use_imm,
    input  logic [IMM_W-1:0]  imm,
    input  logic [WIDTH-1:0]  operand_in,
    output logic [WIDTH-1:0]  acc_out,
    output logic [3:0]        flags,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_LDA = 4'd10;

    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] MUL_REM  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

    // Flag word {Z,N,C,V} for a finished result.
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
        return {(res == {WIDTH{1'b0}}), res[WIDTH-1], c, v};
    endfunction

    // One logical shift; MSB of the return value is the bit shifted out.
    function automatic logic [WIDTH:0] shift_once(input logic [WIDTH-1:0] val,
                                                  input logic left);
        logic [WIDTH:0] r;
        if (left) begin
            r = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
        end else begin
            r = {val[0], 1'b0, val[WIDTH-1:1]};
        end
        return r;
    endfunction

    // One shift-add iteration: low half holds the remaining multiplier bits,
    // high half the running partial product; both shift right together.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] prod,
                                                    input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0] upper;
        if (prod[0]) begin
            upper = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            upper = {1'b0, prod[2*WIDTH-1:WIDTH]};
        end
        return {upper, prod[WIDTH-1:1]};
    endfunction

    state_t               state_r, state_s;
    logic [WIDTH-1:0]     acc_r, acc_s;
    logic [3:0]           flags_r, flags_s;
    logic                 done_r, done_s;
    logic                 err_r, err_s;
    logic [WIDTH-1:0]     work_r, work_s;
    logic                 left_r, left_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [2*WIDTH-1:0]   prod_r, prod_s;
    logic [WIDTH-1:0]     mcand_r, mcand_s;

    logic [WIDTH-1:0]     operand_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic                 add_v_s;
    logic                 sub_v_s;
    logic [CNT_W-1:0]     amt_s;
    logic [WIDTH:0]       sh_acc_s;
    logic [WIDTH:0]       sh_work_s;
    logic [2*WIDTH-1:0]   mul_first_s;
    logic [2*WIDTH-1:0]   mul_next_s;

    assign operand_s   = use_imm ? {{(WIDTH-IMM_W){1'b0}}, imm} : operand_in;
    assign sum_s       = {1'b0, acc_r} + {1'b0, operand_s};
    assign diff_s      = {1'b0, acc_r} - {1'b0, operand_s};
    assign add_v_s     = (acc_r[WIDTH-1] == operand_s[WIDTH-1]) &&
                         (sum_s[WIDTH-1] != acc_r[WIDTH-1]);
    assign sub_v_s     = (acc_r[WIDTH-1] != operand_s[WIDTH-1]) &&
                         (diff_s[WIDTH-1] != acc_r[WIDTH-1]);
    assign amt_s       = (operand_s >= WIDTH_V) ? WIDTH_C : operand_s[CNT_W-1:0];
    assign sh_acc_s    = shift_once(acc_r, (opcode == OP_SHL));
    assign sh_work_s   = shift_once(work_r, left_r);
    assign mul_first_s = mul_step({{WIDTH{1'b0}}, operand_s}, acc_r);
    assign mul_next_s  = mul_step(prod_r, mcand_r);

    assign op_ready = (state_r == ST_IDLE) && !acc_load;
    assign busy     = (state_r != ST_IDLE);
    assign acc_out  = acc_r;
    assign flags    = flags_r;
    assign done     = done_r;
    assign err      = err_r;

    // Next-state and datapath decode: issue in IDLE, iterate in SHIFT/MUL.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        flags_s = flags_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        work_s  = work_r;
        left_s  = left_r;
        cnt_s   = cnt_r;
        prod_s  = prod_r;
        mcand_s = mcand_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_load) begin
                    acc_s = acc_in;
                end else if (op_valid) begin
                    done_s = 1'b1;
                    case (opcode)
                        OP_NOP: begin
                            acc_s = acc_r;
                        end
                        OP_ADD: begin
                            acc_s   = sum_s[WIDTH-1:0];
                            flags_s = mk_flags(sum_s[WIDTH-1:0], sum_s[WIDTH], add_v_s);
                        end
                        OP_SUB: begin
                            acc_s   = diff_s[WIDTH-1:0];
                            flags_s = mk_flags(diff_s[WIDTH-1:0], diff_s[WIDTH], sub_v_s);
                        end
                        OP_AND: begin
                            acc_s   = acc_r & operand_s;
                            flags_s = mk_flags(acc_r & operand_s, 1'b0, 1'b0);
                        end
                        OP_OR: begin
                            acc_s   = acc_r | operand_s;
                            flags_s = mk_flags(acc_r | operand_s, 1'b0, 1'b0);
                        end
                        OP_XOR: begin
                            acc_s   = acc_r ^ operand_s;
                            flags_s = mk_flags(acc_r ^ operand_s, 1'b0, 1'b0);
                        end
                        OP_NOT: begin
                            acc_s   = ~operand_s;
                            flags_s = mk_flags(~operand_s, 1'b0, 1'b0);
                        end
                        OP_LDA: begin
                            acc_s   = operand_s;
                            flags_s = mk_flags(operand_s, 1'b0, 1'b0);
                        end
                        OP_SHL, OP_SHR: begin
                            if (amt_s == CNT_ZERO) begin
                                flags_s = mk_flags(acc_r, 1'b0, 1'b0);
                            end else if (amt_s == CNT_ONE) begin
                                acc_s   = sh_acc_s[WIDTH-1:0];
                                flags_s = mk_flags(sh_acc_s[WIDTH-1:0], sh_acc_s[WIDTH], 1'b0);
                            end else begin
                                // First shift happens on the accept edge.
                                done_s  = 1'b0;
                                state_s = ST_SHIFT;
                                work_s  = sh_acc_s[WIDTH-1:0];
                                left_s  = (opcode == OP_SHL);
                                cnt_s   = amt_s - CNT_ONE;
                            end
                        end
                        OP_MUL: begin
                            // First iteration happens on the accept edge.
                            done_s  = 1'b0;
                            state_s = ST_MUL;
                            prod_s  = mul_first_s;
                            mcand_s = acc_r;
                            cnt_s   = MUL_REM;
                        end
                        default: begin
                            err_s = 1'b1;
                        end
                    endcase
                end else begin
                    acc_s = acc_r;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_IDLE;
                    acc_s   = sh_work_s[WIDTH-1:0];
                    flags_s = mk_flags(sh_work_s[WIDTH-1:0], sh_work_s[WIDTH], 1'b0);
                    done_s  = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    work_s = sh_work_s[WIDTH-1:0];
                    cnt_s  = cnt_r - CNT_ONE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_IDLE;
                    acc_s   = mul_next_s[WIDTH-1:0];
                    flags_s = mk_flags(mul_next_s[WIDTH-1:0],
                                       |mul_next_s[2*WIDTH-1:WIDTH],
                                       |mul_next_s[2*WIDTH-1:WIDTH]);
                    done_s  = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    prod_s = mul_next_s;
                    cnt_s  = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; restart clears everything immediately.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_r <= ST_IDLE;
            acc_r   <= {WIDTH{1'b0}};
            flags_r <= 4'b0000;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            work_r  <= {WIDTH{1'b0}};
            left_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            flags_r <= flags_s;
            done_r  <= done_s;
            err_r   <= err_s;
            work_r  <= work_s;
            left_r  <= left_s;
            cnt_r   <= cnt_s;
            prod_r  <= prod_s;
            mcand_r <= mcand_s;
        end
    end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Self-checking bench for acc_alu_seq (WIDTH=8, IMM_W=4): directed vector
// table, hand-written multi-cycle sequences, and random operations checked
// against an arithmetic reference model.
module tb_acc_alu_seq;

    logic       clka = 1'b0;
    logic       restart;
    logic       acc_load;
    logic [7:0] acc_in;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] opcode;
    logic       use_imm;
    logic [3:0] imm;
    logic [7:0] operand_in;
    logic [7:0] acc_out;
    logic [3:0] flags;
    logic       busy;
    logic       done;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    acc_alu_seq #(.WIDTH(8), .IMM_W(4)) dut (
        .clka(clka), .restart(restart), .acc_load(acc_load), .acc_in(acc_in),
        .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
        .use_imm(use_imm), .imm(imm), .operand_in(operand_in),
        .acc_out(acc_out), .flags(flags), .busy(busy), .done(done), .err(err)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [7:0] acc;
        logic [3:0] flags;
        logic       err;
        int         lat;
    } res_t;

    typedef struct {
        logic       do_ld;
        logic [7:0] ld_val;
        logic [3:0] opc;
        logic       ui;
        logic [3:0] im;
        logic [7:0] opnd;
        logic [7:0] e_acc;
        logic [3:0] e_flags;
        logic       e_err;
        int         e_lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 8-bit values.
    function automatic res_t model(input int a, input logic [3:0] f, input int opc, input int b);
        res_t r;
        int   res, n, sa, sb, s;
        logic c, v, upd;
        r.flags = f; r.err = 1'b0; r.lat = 1;
        res = a; c = 1'b0; v = 1'b0; upd = 1'b1;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        n  = (b > 8) ? 8 : b;
        case (opc)
            0: upd = 1'b0;
            1: begin s = a + b; res = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            2: begin res = (a - b + 256) % 256; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = 255 - b;
            7: begin res = (a << n) % 256; c = (n == 0) ? 1'b0 : (((a >> (8 - n)) & 1) == 1); r.lat = (n == 0) ? 1 : n; end
            8: begin res = a >> n; c = (n == 0) ? 1'b0 : (((a >> (n - 1)) & 1) == 1); r.lat = (n == 0) ? 1 : n; end
            9: begin s = a * b; res = s % 256; c = (s > 255); v = c; r.lat = 8; end
            10: res = b;
            default: begin upd = 1'b0; r.err = 1'b1; end
        endcase
        r.acc = 8'(res);
        if (upd) r.flags = {(res == 0), (res >= 128), c, v};
        return r;
    endfunction

    task automatic ld(input logic [7:0] v);
        acc_load = 1'b1; acc_in = v;
        @(posedge clka); #1;
        acc_load = 1'b0; acc_in = 8'h00;
    endtask

    // Issue one op (caller is 1 time unit after a rising edge), wait for done.
    task automatic do_op(input string nm, input logic [3:0] opc, input logic ui,
                         input logic [3:0] im, input logic [7:0] opnd,
                         input logic [7:0] e_acc, input logic [3:0] e_flags,
                         input logic e_err, input int e_lat);
        int   lat;
        logic busy_bad;
        op_valid = 1'b1; opcode = opc; use_imm = ui; imm = im; operand_in = opnd;
        @(posedge clka); #1;
        op_valid = 1'b0;
        lat = 1; busy_bad = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            @(posedge clka); #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(e_lat));
        check({nm, " acc_out"}, {24'h0, acc_out}, {24'h0, e_acc});
        check({nm, " flags"}, {28'h0, flags}, {28'h0, e_flags});
        check({nm, " err"}, {31'h0, err}, {31'h0, e_err});
        check({nm, " busy_at_done"}, {31'h0, busy}, 32'h0);
        if (e_lat > 1) check({nm, " busy_during"}, {31'h0, busy_bad}, 32'h0);
    endtask

    vec_t tbl[19];

    initial begin
        logic       rdy_bad, busy_bad, hold_bad, done_bad;
        logic [7:0] m_acc;
        logic [3:0] m_flags;
        res_t       r;

        restart = 1'b1; acc_load = 1'b0; acc_in = 8'h00; op_valid = 1'b0;
        opcode = 4'd0; use_imm = 1'b0; imm = 4'h0; operand_in = 8'h00;

        tbl[0]  = '{1'b1, 8'hF0, 4'd1,  1'b0, 4'h0, 8'h20, 8'h10, 4'b0010, 1'b0, 1};
        tbl[1]  = '{1'b1, 8'h05, 4'd2,  1'b1, 4'h5, 8'h00, 8'h00, 4'b1000, 1'b0, 1};
        tbl[2]  = '{1'b0, 8'h00, 4'd2,  1'b1, 4'h1, 8'h00, 8'hFF, 4'b0110, 1'b0, 1};
        tbl[3]  = '{1'b1, 8'h81, 4'd7,  1'b1, 4'h3, 8'h00, 8'h08, 4'b0000, 1'b0, 3};
        tbl[4]  = '{1'b1, 8'h0D, 4'd9,  1'b0, 4'h0, 8'h0B, 8'h8F, 4'b0100, 1'b0, 8};
        tbl[5]  = '{1'b1, 8'h10, 4'd9,  1'b0, 4'h0, 8'h10, 8'h00, 4'b1011, 1'b0, 8};
        tbl[6]  = '{1'b0, 8'h00, 4'd0,  1'b0, 4'h0, 8'h00, 8'h00, 4'b1011, 1'b0, 1};
        tbl[7]  = '{1'b1, 8'h7F, 4'd1,  1'b1, 4'h1, 8'h00, 8'h80, 4'b0101, 1'b0, 1};
        tbl[8]  = '{1'b1, 8'h80, 4'd2,  1'b0, 4'h0, 8'h01, 8'h7F, 4'b0001, 1'b0, 1};
        tbl[9]  = '{1'b1, 8'h55, 4'd8,  1'b1, 4'h0, 8'h00, 8'h55, 4'b0000, 1'b0, 1};
        tbl[10] = '{1'b1, 8'h81, 4'd8,  1'b1, 4'h1, 8'h00, 8'h40, 4'b0010, 1'b0, 1};
        tbl[11] = '{1'b1, 8'h81, 4'd7,  1'b0, 4'h0, 8'hFF, 8'h00, 4'b1010, 1'b0, 8};
        tbl[12] = '{1'b1, 8'hA5, 4'd6,  1'b0, 4'h0, 8'h0F, 8'hF0, 4'b0100, 1'b0, 1};
        tbl[13] = '{1'b0, 8'h00, 4'd12, 1'b0, 4'h0, 8'h00, 8'hF0, 4'b0100, 1'b1, 1};
        tbl[14] = '{1'b1, 8'h3C, 4'd5,  1'b1, 4'hF, 8'h00, 8'h33, 4'b0000, 1'b0, 1};
        tbl[15] = '{1'b1, 8'h3C, 4'd3,  1'b0, 4'h0, 8'hC3, 8'h00, 4'b1000, 1'b0, 1};
        tbl[16] = '{1'b1, 8'h3C, 4'd4,  1'b0, 4'h0, 8'hC3, 8'hFF, 4'b0100, 1'b0, 1};
        tbl[17] = '{1'b1, 8'h12, 4'd10, 1'b0, 4'h0, 8'h80, 8'h80, 4'b0100, 1'b0, 1};
        tbl[18] = '{1'b1, 8'h00, 4'd8,  1'b0, 4'h0, 8'h09, 8'h00, 4'b1000, 1'b0, 8};

        // Reset state
        #12;
        check("rst acc_out", {24'h0, acc_out}, 32'h0);
        check("rst flags", {28'h0, flags}, 32'h0);
        check("rst busy/done/err", {29'h0, busy, done, err}, 32'h0);
        restart = 1'b0;
        @(posedge clka); #1;
        check("rst op_ready", {31'h0, op_ready}, 32'h1);

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].do_ld) begin
                ld(tbl[i].ld_val);
                check($sformatf("vec%0d load", i), {24'h0, acc_out}, {24'h0, tbl[i].ld_val});
                check($sformatf("vec%0d load_no_done", i), {31'h0, done}, 32'h0);
            end
            do_op($sformatf("vec%0d", i), tbl[i].opc, tbl[i].ui, tbl[i].im, tbl[i].opnd,
                  tbl[i].e_acc, tbl[i].e_flags, tbl[i].e_err, tbl[i].e_lat);
        end

        // Backpressure: valid held through MUL, load attempted while busy
        ld(8'h0D);
        op_valid = 1'b1; opcode = 4'd9; use_imm = 1'b0; operand_in = 8'h0B;
        @(posedge clka); #1;
        opcode = 4'd1; use_imm = 1'b1; imm = 4'h1;
        rdy_bad = 1'b0; busy_bad = 1'b0; hold_bad = 1'b0; done_bad = 1'b0;
        for (int c = 1; c < 8; c++) begin
            if (op_ready !== 1'b0) rdy_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (acc_out !== 8'h0D) hold_bad = 1'b1;
            if (done !== 1'b0) done_bad = 1'b1;
            if (c == 2) begin acc_load = 1'b1; acc_in = 8'hAA; end
            if (c == 4) begin acc_load = 1'b0; acc_in = 8'h00; end
            @(posedge clka); #1;
        end
        check("bp op_ready low", {31'h0, rdy_bad}, 32'h0);
        check("bp busy high", {31'h0, busy_bad}, 32'h0);
        check("bp acc hold", {31'h0, hold_bad}, 32'h0);
        check("bp no early done", {31'h0, done_bad}, 32'h0);
        check("bp mul done", {31'h0, done}, 32'h1);
        check("bp mul acc", {24'h0, acc_out}, 32'h8F);
        check("bp ready at done", {31'h0, op_ready}, 32'h1);
        @(posedge clka); #1;
        op_valid = 1'b0;
        check("bp add done", {31'h0, done}, 32'h1);
        check("bp add acc", {24'h0, acc_out}, 32'h90);
        check("bp add flags", {28'h0, flags}, 32'h4);

        // Restart mid-MUL
        op_valid = 1'b1; opcode = 4'd9; use_imm = 1'b0; operand_in = 8'h03;
        @(posedge clka); #1;
        op_valid = 1'b0;
        @(posedge clka); #1;
        #2 restart = 1'b1;
        #1;
        check("abort acc", {24'h0, acc_out}, 32'h0);
        check("abort flags", {28'h0, flags}, 32'h0);
        check("abort busy/done/err", {29'h0, busy, done, err}, 32'h0);
        restart = 1'b0;
        @(posedge clka); #1;
        done_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done !== 1'b0) done_bad = 1'b1;
            @(posedge clka); #1;
        end
        check("abort no done", {31'h0, done_bad}, 32'h0);
        do_op("illegal12", 4'd12, 1'b0, 4'h0, 8'h55, 8'h00, 4'b0000, 1'b1, 1);
        @(posedge clka); #1;
        check("err pulse width", {30'h0, done, err}, 32'h0);

        // Random operations against the reference model
        m_acc = 8'h00; m_flags = 4'b0000;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] opc;
            logic       ui;
            logic [3:0] im;
            logic [7:0] opnd;
            if (i == 0 || $urandom_range(0, 3) == 0) begin
                m_acc = 8'($urandom_range(0, 255));
                ld(m_acc);
            end
            opc  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            ui   = 1'($urandom_range(0, 1));
            im   = 4'($urandom_range(0, 15));
            opnd = 8'($urandom_range(0, 255));
            if ((opc == 4'd7 || opc == 4'd8) && $urandom_range(0, 1) == 1) opnd = 8'($urandom_range(0, 10));
            r = model(int'(m_acc), m_flags, int'(opc), ui ? int'(im) : int'(opnd));
            do_op($sformatf("rnd%0d op%0d", i, opc), opc, ui, im, opnd, r.acc, r.flags, r.err, r.lat);
            m_acc = r.acc; m_flags = r.flags;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
